// File: rtl/mips_multicycle_core.sv
// mips_multicycle_core: multicycle MIPS subset core sharing one ALU and one req/ready memory port.
module mips_multicycle_core #(
  parameter logic [31:0] RESET_PC        = 32'h0000_0000,
  parameter bit          HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] pc,
  output logic        instr_retired,
  output logic        halted
);
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    ALUWB, BRANCH, ADDIEX, ADDIWB, JUMP, ILLEGAL, HALT
  } state_e;
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d, ir_q, ir_d, mdr_q, mdr_d, a_q, a_d, b_q, b_d, alu_q, alu_d;
  logic [31:0] rf_q [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic [5:0]  op, funct, alu_f;
  logic [4:0]  rs, rt, rd;
  logic [31:0] imm, alu_a, alu_b, alu_y;
  logic        funct_ok;
  assign op       = ir_q[31:26];
  assign rs       = ir_q[25:21];
  assign rt       = ir_q[20:16];
  assign rd       = ir_q[15:11];
  assign funct    = ir_q[5:0];
  assign imm      = {{16{ir_q[15]}}, ir_q[15:0]};
  assign funct_ok = funct inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
  // Single ALU: pc+4 in FETCH, branch target in DECODE, otherwise A against B or imm
  always_comb begin
    alu_a = (state_q == FETCH || state_q == DECODE) ? pc_q : a_q;
    alu_b = state_q == FETCH ? 32'd4 : state_q == DECODE ? {imm[29:0], 2'b00} : state_q == EXEC ? b_q : imm;
    alu_f = state_q == EXEC ? funct : 6'h20;
    alu_y = alu_f == 6'h22 ? alu_a - alu_b :
            alu_f == 6'h24 ? alu_a & alu_b :
            alu_f == 6'h25 ? alu_a | alu_b :
            alu_f == 6'h2A ? {31'b0, $signed(alu_a) < $signed(alu_b)} : alu_a + alu_b;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state_q <= FETCH;
    else state_q <= state_d;
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   state_d = mem_ready ? DECODE : FETCH;
      DECODE:  state_d = (op == 6'h23 || op == 6'h2B) ? MEMADR : op == 6'h00 ? EXEC :
                         op == 6'h04 ? BRANCH : op == 6'h08 ? ADDIEX : op == 6'h02 ? JUMP : ILLEGAL;
      MEMADR:  state_d = op == 6'h23 ? MEMRD : MEMWR;
      MEMRD:   state_d = mem_ready ? MEMWB : MEMRD;
      MEMWR:   state_d = mem_ready ? FETCH : MEMWR;
      EXEC:    state_d = funct_ok ? ALUWB : ILLEGAL;
      ADDIEX:  state_d = ADDIWB;
      ILLEGAL: state_d = HALT_ON_ILLEGAL ? HALT : FETCH;
      HALT:    state_d = HALT;
      default: state_d = FETCH;
    endcase
  end
  // mem_req is gated by rst because the reset state FETCH would otherwise request
  always_comb begin
    mem_req       = !rst && (state_q == FETCH || state_q == MEMRD || state_q == MEMWR);
    mem_we        = !rst && state_q == MEMWR;
    mem_addr      = state_q == FETCH ? pc_q : alu_q;
    mem_wdata     = b_q;
    pc            = pc_q;
    instr_retired = (state_q inside {MEMWB, ALUWB, BRANCH, ADDIWB, JUMP}) ||
                    (state_q == MEMWR && mem_ready) || (state_q == ILLEGAL && !HALT_ON_ILLEGAL);
    halted        = state_q == HALT;
  end
  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    mdr_d = mdr_q;
    a_d   = a_q;
    b_d   = b_q;
    alu_d = alu_q;
    rf_we = 1'b0;
    rf_wa = rt;
    rf_wd = alu_q;
    case (state_q)
      FETCH:                begin ir_d = mem_ready ? mem_rdata : ir_q; pc_d = mem_ready ? alu_y : pc_q; end
      DECODE:               begin a_d = rf_q[rs]; b_d = rf_q[rt]; alu_d = alu_y; end
      MEMADR, EXEC, ADDIEX: alu_d = alu_y;
      MEMRD:                mdr_d = mem_ready ? mem_rdata : mdr_q;
      MEMWB:                begin rf_we = 1'b1; rf_wd = mdr_q; end
      ALUWB:                begin rf_we = 1'b1; rf_wa = rd; end
      ADDIWB:               rf_we = 1'b1;
      BRANCH:               pc_d = a_q == b_q ? alu_q : pc_q;
      JUMP:                 pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
      default:              ;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q  <= RESET_PC;
      ir_q  <= '0;
      mdr_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      alu_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      mdr_q <= mdr_d;
      a_q   <= a_d;
      b_q   <= b_d;
      alu_q <= alu_d;
    end
  // Register 0 is never written, so it always reads back as zero
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < 32; i++) rf_q[i] <= '0;
    else if (rf_we && rf_wa != 5'd0) rf_q[rf_wa] <= rf_wd;
endmodule

// File: tb/tb_mips_multicycle_core.sv
// tb_mips_multicycle_core: random and directed programs checked against an instruction-level model.
module tb_mips_multicycle_core;
  logic        clk = 1'b0, rst = 1'b1, mem_ready = 1'b0;
  logic        mem_req, mem_we, instr_retired, halted;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, pc;
  logic        n_req, n_we, n_ret, n_halt;
  logic [31:0] n_addr, n_wdata, n_pc;
  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic [31:0] r [32];
  logic [31:0] iss_pc;
  logic [31:0] prog [$];
  int          errors = 0, checks = 0;

  always #5 clk = ~clk;
  assign mem_rdata = mem[mem_addr[11:2]];

  mips_multicycle_core u_dut (
    .clk(clk), .rst(rst), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .pc(pc),
    .instr_retired(instr_retired), .halted(halted)
  );

  mips_multicycle_core #(.HALT_ON_ILLEGAL(1'b0)) u_nop (
    .clk(clk), .rst(rst), .mem_req(n_req), .mem_we(n_we), .mem_addr(n_addr),
    .mem_wdata(n_wdata), .mem_rdata(32'hFC00_0000), .mem_ready(1'b1), .pc(n_pc),
    .instr_retired(n_ret), .halted(n_halt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rt_i(input int rs, input int rt, input int rd, input logic [5:0] f);
    return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, f};
  endfunction

  function automatic logic [31:0] it_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] im);
    return {op, 5'(rs), 5'(rt), im};
  endfunction

  // Store r1..r7 to 0x884.. so the final register file is visible, then stop on an illegal word
  task automatic add_tail(input bit bad_funct);
    for (int k = 1; k < 8; k++) prog.push_back(it_i(6'h2B, 0, k, 16'(32'h880 + 4 * k)));
    prog.push_back(bad_funct ? rt_i(0, 0, 0, 6'h3F) : 32'hFC00_0000);
  endtask

  task automatic gen_rand();
    logic [5:0] fs [5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    int n = 20;
    prog = {};
    for (int i = 0; i < n; i++) begin
      int k = $urandom_range(0, 6);
      int a = $urandom_range(0, 7);
      int b = $urandom_range(0, 7);
      int d = $urandom_range(0, 7);
      logic [15:0] im = $urandom_range(0, 1) ? 16'($urandom) : 16'($urandom_range(0, 8) - 4);
      case (k)
        0:       prog.push_back(it_i(6'h08, a, b, im));
        3:       prog.push_back(it_i(6'h2B, 0, b, 16'(32'h800 + 4 * $urandom_range(0, 15))));
        4:       prog.push_back(it_i(6'h23, 0, b, 16'(32'h800 + 4 * $urandom_range(0, 15))));
        5:       prog.push_back(it_i(6'h04, a % 4, b % 4, 16'($urandom_range(0, n - 1 - i))));
        6:       prog.push_back({6'h02, 26'($urandom_range(i + 1, n))});
        default: prog.push_back(rt_i(a, b, d, fs[$urandom_range(0, 4)]));
      endcase
    end
    add_tail(1'($urandom_range(0, 1)));
  endtask

  task automatic load_prog();
    for (int i = 0; i < 1024; i++) mem[i] = i >= 512 ? $urandom : 32'hFC00_0000;
    foreach (prog[i]) mem[i] = prog[i];
    ref_mem = mem;
    for (int i = 0; i < 32; i++) r[i] = '0;
    iss_pc = '0;
  endtask

  // Architectural model: executes one whole instruction; leaves state untouched if illegal
  task automatic iss_step(output int base, output bit ill, output bit st, output logic [31:0] sa, output logic [31:0] sd);
    logic [31:0] w, a, b, imm, ea, v, npc;
    logic [5:0]  op, f;
    int          rs, rt, rd;
    w   = ref_mem[iss_pc[11:2]];
    op  = w[31:26];
    f   = w[5:0];
    rs  = int'(w[25:21]);
    rt  = int'(w[20:16]);
    rd  = int'(w[15:11]);
    imm = {{16{w[15]}}, w[15:0]};
    a   = r[rs];
    b   = r[rt];
    ea  = a + imm;
    npc = iss_pc + 4;
    base = 0; ill = 1'b0; st = 1'b0; sa = '0; sd = '0;
    if (op == 6'h00) begin
      base = 4;
      ill  = !(f inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A});
      v = f == 6'h20 ? a + b : f == 6'h22 ? a - b : f == 6'h24 ? a & b : f == 6'h25 ? a | b :
          ($signed(a) < $signed(b) ? 32'd1 : 32'd0);
      if (!ill && rd != 0) r[rd] = v;
    end else if (op == 6'h08) begin
      base = 4;
      if (rt != 0) r[rt] = ea;
    end else if (op == 6'h23) begin
      base = 5;
      if (rt != 0) r[rt] = ref_mem[ea[11:2]];
    end else if (op == 6'h2B) begin
      base = 4; st = 1'b1; sa = ea; sd = b;
      ref_mem[ea[11:2]] = b;
    end else if (op == 6'h04) begin
      base = 3;
      if (a == b) npc = npc + (imm << 2);
    end else if (op == 6'h02) begin
      base = 3;
      npc = {npc[31:28], w[25:0], 2'b00};
    end else ill = 1'b1;
    if (!ill) iss_pc = npc;
  endtask

  task automatic run_program(input bit rnd, input bit abort);
    int          cyc = 0, waits = 0, tot = 0, nab = 0, base;
    bit          ill, st, pc_chk = 1'b0, done = 1'b0, first = 1'b1, was_wait = 1'b0;
    logic [31:0] sa, sd, p_addr = '0, p_wdata = '0;
    logic        p_req = 1'b0, p_we = 1'b0;
    logic [31:0] sq [$];
    rst = 1'b1;
    mem_ready = 1'b0;
    load_prog();
    @(negedge clk);
    #1;
    check("rst_req", 32'(mem_req), 0);
    check("rst_pc", pc, 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_retired", 32'(instr_retired), 0);
    @(negedge clk);
    rst = 1'b0;
    while (!done) begin
      #1;
      if (first) begin
        check("first_req", 32'(mem_req), 1);
        check("first_addr", mem_addr, 0);
        first = 1'b0;
      end
      if (was_wait) begin
        check("hold_ctl", {30'b0, mem_req, mem_we}, {30'b0, p_req, p_we});
        check("hold_addr", mem_addr, p_addr);
        check("hold_wdata", mem_wdata, p_wdata);
      end
      if (pc_chk) begin
        check("pc", pc, iss_pc);
        pc_chk = 1'b0;
      end
      mem_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      if (abort && mem_req && !mem_we && mem_addr[11]) begin
        mem_ready = 1'b0;
        nab++;
        if (nab == 4) begin
          rst = 1'b1;
          #1;
          check("abort_req", 32'(mem_req), 0);
          check("abort_pc", pc, 0);
          return;
        end
      end
      #1;
      cyc++;
      tot++;
      if (mem_req && !mem_ready) waits++;
      was_wait = mem_req && !mem_ready;
      p_req = mem_req; p_we = mem_we; p_addr = mem_addr; p_wdata = mem_wdata;
      if (mem_req && mem_we && mem_ready) begin
        sq.push_back(mem_addr);
        sq.push_back(mem_wdata);
        mem[mem_addr[11:2]] = mem_wdata;
      end
      if (halted) begin
        iss_step(base, ill, st, sa, sd);
        check("halt_on_illegal", 32'(ill), 1);
        done = 1'b1;
      end else if (instr_retired) begin
        iss_step(base, ill, st, sa, sd);
        check("retire_legal", 32'(ill), 0);
        check("cycles", 32'(cyc), 32'(base + waits));
        check("store_count", 32'(sq.size()), st ? 2 : 0);
        if (st && sq.size() == 2) begin
          check("store_addr", sq.pop_front(), sa);
          check("store_data", sq.pop_front(), sd);
        end
        sq = {};
        cyc = 0;
        waits = 0;
        pc_chk = 1'b1;
      end
      if (tot > 4000) begin
        check("timeout", 1, 0);
        done = 1'b1;
      end
      if (!done) @(negedge clk);
    end
    repeat (6) begin
      @(negedge clk);
      #1;
      check("halt_state", {29'b0, halted, mem_req, instr_retired}, 32'h4);
    end
  endtask

  initial begin
    int nret = 0;
    prog = {32'h2001_0005};
    add_tail(1'b0);
    run_program(1'b0, 1'b0);
    prog = {it_i(6'h08, 0, 1, 7), it_i(6'h08, 0, 2, 3), rt_i(1, 2, 3, 6'h22), rt_i(2, 1, 4, 6'h2A)};
    add_tail(1'b0);
    run_program(1'b0, 1'b0);
    prog = {it_i(6'h08, 0, 3, 4), it_i(6'h2B, 0, 3, 16'h0808), it_i(6'h23, 0, 5, 16'h0808)};
    add_tail(1'b1);
    run_program(1'b1, 1'b0);
    prog = {it_i(6'h08, 0, 5, 3), it_i(6'h08, 0, 6, 1), it_i(6'h08, 0, 1, 0), it_i(6'h08, 1, 1, 1),
            rt_i(1, 5, 4, 6'h2A), it_i(6'h04, 4, 6, 16'hFFFD), {6'h02, 26'd8}, it_i(6'h08, 0, 7, 99),
            it_i(6'h04, 1, 2, 1)};
    add_tail(1'b0);
    run_program(1'b1, 1'b0);
    prog = {it_i(6'h08, 0, 1, 9), it_i(6'h23, 0, 2, 16'h0800)};
    add_tail(1'b0);
    run_program(1'b1, 1'b1);
    prog = {};
    add_tail(1'b0);
    run_program(1'b1, 1'b0);
    repeat (6) begin
      gen_rand();
      run_program(1'b1, 1'b0);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (n_ret) nret++;
      @(negedge clk);
    end
    check("nop_retires", 32'(nret), 10);
    check("nop_pc", n_pc, 40);
    check("nop_halted", 32'(n_halt), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
